shift_add_mul: RTL and testbench

//  Sequential binary multiplier using the shift-and-add algorithm, one multiplier bit per clock.

---
 rtl/shift_add_mul_pkg.sv | 16 +
 rtl/shift_add_mul_if.sv | 24 ++
 rtl/shift_add_mul_add_step.sv | 24 ++
 rtl/shift_add_mul.sv | 90 +++++++++
 tb/tb_shift_add_mul.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/shift_add_mul_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// FSM state encoding and counter width helper.
`timescale 1ns/1ps
package shift_add_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_mul_if.sv
// Start/Done handshake and operand/product bus of the multiplier.
// master drives requests; slave is the multiplier.
`timescale 1ns/1ps
interface shift_add_mul_if #(
    parameter int L = 16,
    parameter int l = 3
);
    logic             Start;
    logic [L-1:0]     Multiplicand;
    logic [l-1:0]     Multiplier;
    logic             Busy;
    logic             Done;
    logic [L+l-1:0]   P;

    modport master (
        output Start, Multiplicand, Multiplier,
        input  Busy, Done, P
    );

    modport slave (
        input  Start, Multiplicand, Multiplier,
        output Busy, Done, P
    );
endinterface

// File: rtl/shift_add_mul_add_step.sv
// One shift-and-add iteration: conditional add of M, then
// a logical right shift of {sum,Q} by one bit.
`timescale 1ns/1ps
module mul_add_step #(
    parameter int L = 16,
    parameter int l = 3
) (
    input  logic [L:0]   a_i,
    input  logic [L-1:0] m_i,
    input  logic [l-1:0] q_i,
    output logic [L:0]   a_o,
    output logic [l-1:0] q_o
);
    logic [L:0]   sum;
    logic [L+l:0] cat;

    // Add M when the current multiplier LSB is set, then shift right.
    always_comb begin
        sum = q_i[0] ? (a_i + {1'b0, m_i}) : a_i;
        cat = {sum, q_i} >> 1;
        a_o = cat[L+l:l];
        q_o = cat[l-1:0];
    end
endmodule

// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Optional MUL_ZERO_SKIP_EN: zero operands finish without RUN.
`timescale 1ns/1ps
module shift_add_mul
    import shift_add_mul_pkg::*;
#(
    parameter int L = 16,
    parameter int l = 3
) (
    input  logic           Clk,
    input  logic           Rst,
    shift_add_mul_if.slave bus
);
    localparam int CW = cnt_width(l);

    state_e          state_q, state_d;
    logic [L-1:0]    m_q, m_d;
    logic [L:0]      a_q, a_d;
    logic [l-1:0]    q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [L:0]      step_a;
    logic [l-1:0]    step_q;
    logic            accept;

    mul_add_step #(.L(L), .l(l)) u_step (
        .a_i (a_q),
        .m_i (m_q),
        .q_i (q_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    assign accept   = bus.Start && (state_q == IDLE || state_q == DONE);
    assign bus.Busy = (state_q == RUN);
    assign bus.Done = (state_q == DONE);
    assign bus.P    = {a_q[L-1:0], q_q};

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept operands, iterate, finish after l steps.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (accept) begin
                    m_d     = bus.Multiplicand;
                    q_d     = bus.Multiplier;
                    a_d     = '0;
                    cnt_d   = CW'(l);
                    state_d = RUN;
`ifdef MUL_ZERO_SKIP_EN
                    if (bus.Multiplicand == '0 ||
                        bus.Multiplier == '0) begin
                        q_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul (L=16, l=3).
// Random and directed operations against a product/latency model.
`timescale 1ns/1ps
module tb_shift_add_mul;
    localparam int L = 16;
    localparam int l = 3;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    shift_add_mul_if #(.L(L), .l(l)) ifc ();

    shift_add_mul #(.L(L), .l(l)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (ifc.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input longint unsigned obs,
                         input longint unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference latency, counted in edges including the accepting edge.
    function automatic int ref_lat(input longint unsigned a,
                                   input longint unsigned b);
`ifdef MUL_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 1;
`endif
        return l + 1;
    endfunction

    // Start must already be driven; the next edge is the accepting one.
    task automatic wait_done(input string tag,
                             input longint unsigned exp_p,
                             input int exp_lat);
        int  busy_n = 0;
        int  lat    = 0;
        bit  got    = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge Clk);
            #1;
            if (k == 1) begin
                ifc.Start        = 1'b0;
                ifc.Multiplicand = 16'($urandom);
                ifc.Multiplier   = 3'($urandom);
            end
            if (ifc.Busy) busy_n++;
            if (ifc.Done) begin
                got = 1;
                lat = k;
            end
        end
        if (got) begin
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_p"}, ifc.P, exp_p);
            check({tag, "_busy"}, busy_n, exp_lat - 1);
        end else begin
            check({tag, "_timeout"}, 0, 1);
        end
    endtask

    task automatic start_op(input longint unsigned a,
                            input longint unsigned b);
        ifc.Start        = 1'b1;
        ifc.Multiplicand = 16'(a);
        ifc.Multiplier   = 3'(b);
    endtask

    task automatic done_width(input string tag,
                              input longint unsigned exp_p);
        @(posedge Clk);
        #1;
        check({tag, "_dw"}, ifc.Done, 0);
        check({tag, "_hold"}, ifc.P, exp_p);
    endtask

    initial begin
        longint unsigned a, b, p;
        bit chain;
        ifc.Start        = 1'b0;
        ifc.Multiplicand = '0;
        ifc.Multiplier   = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", ifc.Busy, 0);
        check("rst_done", ifc.Done, 0);
        check("rst_p", ifc.P, 0);
        @(negedge Clk);
        Rst = 1'b0;

        @(negedge Clk);
        start_op(36, 7);
        wait_done("t1", 252, ref_lat(36, 7));
        done_width("t1", 252);

        @(negedge Clk);
        start_op(781, 6);
        wait_done("t2", 4686, ref_lat(781, 6));
        @(negedge Clk);
        start_op(92, 5);
        wait_done("t2r", 460, ref_lat(92, 5));
        check("t2_rebuild", ifc.P + 3, 463);

        @(negedge Clk);
        start_op(16'hFFFF, 7);
        wait_done("t3", 458745, ref_lat(16'hFFFF, 7));

        @(negedge Clk);
        start_op(0, 5);
        wait_done("t4", 0, ref_lat(0, 5));
        done_width("t4", 0);

        @(negedge Clk);
        start_op(36, 7);
        @(posedge Clk);
        #1;
        ifc.Start = 1'b0;
        @(posedge Clk);
        #1;
        start_op(100, 3);
        @(posedge Clk);
        #1;
        ifc.Start = 1'b0;
        check("t5_busy", ifc.Busy, 1);
        @(posedge Clk);
        #1;
        check("t5_done", ifc.Done, 1);
        check("t5_p", ifc.P, 252);
        start_op(100, 3);
        wait_done("t5b", 300, ref_lat(100, 3));
        done_width("t5b", 300);

        @(negedge Clk);
        start_op(781, 6);
        @(posedge Clk);
        #1;
        ifc.Start = 1'b0;
        @(posedge Clk);
        #3;
        Rst = 1'b1;
        #1;
        check("t6_p", ifc.P, 0);
        check("t6_busy", ifc.Busy, 0);
        check("t6_done", ifc.Done, 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        start_op(463, 5);
        wait_done("t6b", 2315, ref_lat(463, 5));
        done_width("t6b", 2315);

        chain = 0;
        for (int i = 0; i < 24; i++) begin
            a = longint'($urandom_range(0, 65535));
            b = longint'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) a = 0;
            p = a * b;
            if (!chain) @(negedge Clk);
            start_op(a, b);
            wait_done($sformatf("rnd%0d", i), p, ref_lat(a, b));
            chain = ($urandom_range(0, 2) == 0);
            if (!chain) done_width($sformatf("rnd%0d", i), p);
        end

        repeat (2) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
